// File: rtl/usart_pkg.sv
// Shared UART definitions: rx state encoding, minimum bit period, data width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package usart_pkg;

  localparam int MIN_CPB = 4;
  localparam int DATA_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE,
    PARITY
  } rx_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser bringing an asynchronous input into the local clock domain.
// Latency: STAGES cycles from d to q.
// Backpressure: none; the input is sampled every cycle.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw input through the flop chain; reset presets the chain to the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/usart_rx_buffered.sv
// UART receiver (8N1, or 8E1 when USART_RX_PARITY_EN is defined) feeding a one-entry holding register.
// Latency: byte presented one cycle after the stop-bit sample, i.e. about 9.5 bit times plus sync delay.
// Backpressure: out_valid/out_ready handshake; rts_n mirrors a full holding register, new bytes overrun when full.
module usart_rx_buffered
  import usart_pkg::*;
#(
  parameter int CPB_WIDTH   = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 serial_clock,
  input  logic                 reset,
  input  logic [CPB_WIDTH-1:0] clocks_per_bit,
  input  logic                 rx_pin,
  output logic                 rts_n,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 framing_error,
  output logic                 overrun,
`ifdef USART_RX_PARITY_EN
  output logic                 parity_error,
`endif
  input  logic                 clear_errors
);

  rx_state_t              state, state_d;
  logic                   rx_s;
  logic [CPB_WIDTH-1:0]   cpb, cpb_eff, bit_cnt;
  logic [2:0]             idx;
  logic [DATA_W-1:0]      shreg;
  logic                   sample, accept, load_byte, set_fe, set_ov, set_pe, par_bad;

  sync_ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (serial_clock),
    .rst_n (reset),
    .d     (rx_pin),
    .q     (rx_s)
  );

  // Very short bit periods are clamped so the half-bit start offset stays meaningful.
  assign cpb_eff = (clocks_per_bit < CPB_WIDTH'(MIN_CPB)) ? CPB_WIDTH'(MIN_CPB) : clocks_per_bit;
  assign sample  = (bit_cnt == CPB_WIDTH'(1));
  assign accept  = out_valid & out_ready;

  // State register.
  always_ff @(posedge serial_clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state decode and per-frame events (load, framing, overrun, parity).
  always_comb begin
    state_d   = state;
    load_byte = 1'b0;
    set_fe    = 1'b0;
    set_ov    = 1'b0;
    set_pe    = 1'b0;
    case (state)
      IDLE:  if (!rx_s) state_d = START;
      START: if (sample) state_d = rx_s ? IDLE : DATA;
      DATA: begin
        if (sample && idx == 3'd7) begin
`ifdef USART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef USART_RX_PARITY_EN
      PARITY: begin
        if (sample) begin
          state_d = STOP;
          set_pe  = (^shreg) ^ rx_s;
        end
      end
`endif
      STOP: begin
        if (sample) begin
          if (rx_s) begin
            state_d = IDLE;
            if (!par_bad) begin
              if (!out_valid || accept) load_byte = 1'b1;
              else                      set_ov    = 1'b1;
            end
          end else begin
            state_d = WAIT_IDLE;
            set_fe  = 1'b1;
          end
        end
      end
      // Stay here until the line has been high a full bit period so a break cannot retrigger.
      WAIT_IDLE: if (rx_s && sample) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bit timer, bit index and LSB-first shift register.
  always_ff @(posedge serial_clock or negedge reset) begin
    if (!reset) begin
      cpb     <= CPB_WIDTH'(MIN_CPB);
      bit_cnt <= '0;
      idx     <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            cpb     <= cpb_eff;
            bit_cnt <= cpb_eff >> 1;
          end
        end
        WAIT_IDLE: bit_cnt <= rx_s ? (bit_cnt - CPB_WIDTH'(1)) : cpb;
        default:   bit_cnt <= sample ? cpb : (bit_cnt - CPB_WIDTH'(1));
      endcase
      if (state == START && sample) idx <= '0;
      if (state == DATA && sample) begin
        shreg <= {rx_s, shreg[DATA_W-1:1]};
        idx   <= idx + 3'd1;
      end
    end
  end

`ifdef USART_RX_PARITY_EN
  // Remember a parity mismatch until the stop bit decides the fate of the byte.
  always_ff @(posedge serial_clock or negedge reset) begin
    if (!reset)                        par_bad <= 1'b0;
    else if (state == PARITY && sample) par_bad <= set_pe;
  end

  // Sticky parity flag; a set in the same cycle as a clear wins.
  always_ff @(posedge serial_clock or negedge reset) begin
    if (!reset) parity_error <= 1'b0;
    else        parity_error <= set_pe | (parity_error & ~clear_errors);
  end
`else
  assign par_bad = 1'b0;
`endif

  // Holding register; a load in the same cycle as an accept keeps out_valid high.
  always_ff @(posedge serial_clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      rts_n     <= 1'b0;
    end else if (load_byte) begin
      out_valid <= 1'b1;
      out_data  <= shreg;
      rts_n     <= 1'b1;
    end else if (accept) begin
      out_valid <= 1'b0;
      rts_n     <= 1'b0;
    end
  end

  // Sticky framing and overrun flags; a set in the same cycle as a clear wins.
  always_ff @(posedge serial_clock or negedge reset) begin
    if (!reset) begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= set_fe | (framing_error & ~clear_errors);
      overrun       <= set_ov | (overrun & ~clear_errors);
    end
  end

endmodule

// File: tb/tb_usart_rx_buffered.sv
// Directed bench for usart_rx_buffered at 32 clocks per bit.
// Latency: n/a.
// Backpressure: exercised via out_ready hold-off and same-cycle accept/load.
module tb_usart_rx_buffered;

`ifdef USART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Fall negedge -> posedges P0..P(18+32*(FRAME_BITS-1)) -> out_valid seen at next negedge.
  localparam int STOP_EDGE = 18 + 32 * (FRAME_BITS - 1);
  localparam int EXP_LAT   = STOP_EDGE + 1;

  logic        serial_clock = 1'b0;
  logic        reset        = 1'b0;
  logic [11:0] clocks_per_bit = 12'd32;
  logic        rx_pin       = 1'b1;
  logic        out_ready    = 1'b0;
  logic        clear_errors = 1'b0;
  logic        rts_n, out_valid, framing_error, overrun;
  logic [7:0]  out_data;
`ifdef USART_RX_PARITY_EN
  logic        parity_error;
  logic        par_flip = 1'b0;
`endif

  usart_rx_buffered dut (
    .serial_clock   (serial_clock),
    .reset          (reset),
    .clocks_per_bit (clocks_per_bit),
    .rx_pin         (rx_pin),
    .rts_n          (rts_n),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .framing_error  (framing_error),
    .overrun        (overrun),
`ifdef USART_RX_PARITY_EN
    .parity_error   (parity_error),
`endif
    .clear_errors   (clear_errors)
  );

  always #5 serial_clock = ~serial_clock;

  int cyc = 0;
  always @(posedge serial_clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled just after the falling edge.
  int         acc_cnt = 0, valid_cyc = 0, drop_cnt = 0, t_valid = 0, t_fall = 0;
  logic [7:0] last_acc = 8'h00;
  logic       prev_valid = 1'b0;
  always @(negedge serial_clock) begin
    #1;
    if (out_valid && !prev_valid) t_valid = cyc;
    if (prev_valid && !out_valid) drop_cnt++;
    if (out_valid) valid_cyc++;
    if (out_valid && out_ready) begin
      acc_cnt++;
      last_acc = out_data;
    end
    prev_valid = out_valid;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge serial_clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge serial_clock);
    rx_pin = 1'b0;
    t_fall = cyc;
    idle(32);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      idle(32);
    end
`ifdef USART_RX_PARITY_EN
    rx_pin = (^b) ^ par_flip;
    idle(32);
`endif
    rx_pin = stop_bit;
    idle(32);
    rx_pin = 1'b1;
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    idle(1);
    clear_errors = 1'b0;
    idle(1);
  endtask

  int a0, v0, d0, lat;

  initial begin
    // Reset state
    idle(3);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'h00);
    check("rst_rts", 32'(rts_n), 32'd0);
    check("rst_fe", 32'(framing_error), 32'd0);
    check("rst_ov", 32'(overrun), 32'd0);
`ifdef USART_RX_PARITY_EN
    check("rst_pe", 32'(parity_error), 32'd0);
`endif
    reset = 1'b1;
    idle(10);

    // Normal frame with the consumer always ready
    out_ready = 1'b1;
    a0 = acc_cnt; v0 = valid_cyc;
    send_frame(8'h55, 1'b1);
    idle(20);
    lat = t_valid - t_fall;
    check("nrm_acc", 32'(acc_cnt - a0), 32'd1);
    check("nrm_data", 32'(last_acc), 32'h55);
    check("nrm_pulse", 32'(valid_cyc - v0), 32'd1);
    check("nrm_lat", 32'(lat), 32'(EXP_LAT));
    check("nrm_fe", 32'(framing_error), 32'd0);
    check("nrm_ov", 32'(overrun), 32'd0);

    // Back-pressure and overrun
    out_ready = 1'b0;
    send_frame(8'hA3, 1'b1);
    idle(5);
    check("bp_rts", 32'(rts_n), 32'd1);
    check("bp_ov0", 32'(overrun), 32'd0);
    send_frame(8'h3C, 1'b1);
    idle(5);
    check("bp_data", 32'(out_data), 32'hA3);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_ov", 32'(overrun), 32'd1);
    a0 = acc_cnt;
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    idle(1);
    check("bp_acc", 32'(acc_cnt - a0), 32'd1);
    check("bp_acc_data", 32'(last_acc), 32'hA3);
    check("bp_valid_clr", 32'(out_valid), 32'd0);
    check("bp_rts_clr", 32'(rts_n), 32'd0);
    pulse_clear();
    check("bp_ov_clr", 32'(overrun), 32'd0);

    // Framing error followed by a break and a short idle gap
    out_ready = 1'b1;
    a0 = acc_cnt;
    send_frame(8'hFF, 1'b0);
    rx_pin = 1'b0;
    idle(100);
    check("fe_set", 32'(framing_error), 32'd1);
    rx_pin = 1'b1;
    idle(20);
    rx_pin = 1'b0;
    idle(32);
    rx_pin = 1'b1;
    idle(400);
    check("fe_no_byte", 32'(acc_cnt - a0), 32'd0);
    check("fe_sticky", 32'(framing_error), 32'd1);
    pulse_clear();
    check("fe_clr", 32'(framing_error), 32'd0);

    // Glitch rejection
    a0 = acc_cnt; v0 = valid_cyc;
    rx_pin = 1'b0;
    idle(5);
    rx_pin = 1'b1;
    idle(400);
    check("gl_acc", 32'(acc_cnt - a0), 32'd0);
    check("gl_valid", 32'(valid_cyc - v0), 32'd0);
    check("gl_flags", 32'({framing_error, overrun}), 32'd0);

    // Accept and load in the same cycle
    out_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    idle(5);
    a0 = acc_cnt; d0 = drop_cnt;
    fork
      send_frame(8'h22, 1'b1);
      begin
        @(negedge serial_clock);
        idle(STOP_EDGE);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
      end
    join
    idle(5);
    check("al_acc", 32'(acc_cnt - a0), 32'd1);
    check("al_acc_data", 32'(last_acc), 32'h11);
    check("al_no_drop", 32'(drop_cnt - d0), 32'd0);
    check("al_data", 32'(out_data), 32'h22);
    check("al_valid", 32'(out_valid), 32'd1);
    check("al_ov", 32'(overrun), 32'd0);

    // Reset mid-DATA with a full holding register
    rx_pin = 1'b0;
    idle(32);
    rx_pin = 1'b1;
    idle(60);
    reset = 1'b0;
    idle(2);
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_data", 32'(out_data), 32'h00);
    check("mr_rts", 32'(rts_n), 32'd0);
    check("mr_flags", 32'({framing_error, overrun}), 32'd0);
    reset = 1'b1;
    idle(50);
    out_ready = 1'b1;
    a0 = acc_cnt;
    send_frame(8'h12, 1'b1);
    idle(20);
    check("mr_acc", 32'(acc_cnt - a0), 32'd1);
    check("mr_acc_data", 32'(last_acc), 32'h12);
    check("mr_flags2", 32'({framing_error, overrun}), 32'd0);

`ifdef USART_RX_PARITY_EN
    // Wrong parity bit on 0x07
    a0 = acc_cnt;
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    idle(20);
    check("par_err", 32'(parity_error), 32'd1);
    check("par_no_byte", 32'(acc_cnt - a0), 32'd0);
    pulse_clear();
    check("par_clr", 32'(parity_error), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
